dstrobe_tx: RTL

DSTROBE_TX -- requirements
Module: dstrobe_tx

---
 rtl/dstrobe_pkg.sv | 22 ++
 rtl/dstrobe_tx_tmo_counter.sv | 32 +++
 rtl/dstrobe_tx.sv | 112 +++++++++++
 3 files changed

// File: rtl/dstrobe_pkg.sv
// Shared types and defaults for the data-strobe transmitter.
// Holds the FSM state encoding and the default parameter values.
package dstrobe_pkg;

  localparam int LEN_W_DEF      = 8;
  localparam int TMO_CYCLES_DEF = 255;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ENGAGE   = 3'd1,
    ST_WAIT_RX  = 3'd2,
    ST_STROBE   = 3'd3,
    ST_WAIT_RDY = 3'd4,
    ST_DONE     = 3'd5,
    ST_ERROR    = 3'd6
  } state_e;

  function automatic logic is_wait(state_e s);
    return (s == ST_WAIT_RX) || (s == ST_WAIT_RDY);
  endfunction

endpackage

// File: rtl/dstrobe_tx_tmo_counter.sv
// Wait-state timeout counter for dstrobe_tx.
// Expires on the TMO_CYCLES-th consecutive enabled cycle.
module tmo_counter #(
  parameter int TMO_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = (TMO_CYCLES > 1) ? $clog2(TMO_CYCLES) : 1;
  localparam logic [CW-1:0] ONE  = CW'(1);
  localparam logic [CW-1:0] LAST = CW'(TMO_CYCLES - 1);

  logic [CW-1:0] count;

  assign expired = enable && (count == LAST);

  // Saturates at LAST so a late exit can never wrap the count
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + ONE;
    end
  end

endmodule

// File: rtl/dstrobe_tx.sv
// Data-strobe transmitter: engages a receiver, sends a strobe of
// burst_len cycles, and waits for the receiver to report data ready.
module dstrobe_tx
  import dstrobe_pkg::*;
#(
  parameter int LEN_W      = LEN_W_DEF,
  parameter int TMO_CYCLES = TMO_CYCLES_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] burst_len,
  input  logic             abort,
  input  logic             rx_waiting,
  input  logic             rx_data_ready,
  output logic             eng,
  output logic             d_s,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam logic [LEN_W-1:0] ONE = LEN_W'(1);

  state_e           state;
  state_e           state_nx;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] cnt;
  logic             tmo_clr;
  logic             tmo_en;
  logic             tmo_exp;
  logic             accept;
  logic             rx_go;

  assign tmo_en  = is_wait(state);
  assign tmo_clr = !tmo_en;
  assign accept  = (state == ST_IDLE) && start;
  assign rx_go   = (state == ST_WAIT_RX) && rx_waiting;

  tmo_counter #(
    .TMO_CYCLES(TMO_CYCLES)
  ) u_tmo (
    .clk    (clk),
    .rst    (rst),
    .clear  (tmo_clr),
    .enable (tmo_en),
    .expired(tmo_exp)
  );

  // Awaited input is tested before the timeout so it wins a tie
  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          state_nx = (burst_len == '0) ? ST_ERROR : ST_ENGAGE;
        end
      end
      ST_ENGAGE: state_nx = ST_WAIT_RX;
      ST_WAIT_RX: begin
        if (rx_waiting) begin
          state_nx = ST_STROBE;
        end else if (tmo_exp) begin
          state_nx = ST_ERROR;
        end
      end
      ST_STROBE: begin
        if (cnt == ONE) begin
          state_nx = ST_WAIT_RDY;
        end
      end
      ST_WAIT_RDY: begin
        if (rx_data_ready) begin
          state_nx = ST_DONE;
        end else if (tmo_exp) begin
          state_nx = ST_ERROR;
        end
      end
      ST_DONE:  state_nx = ST_IDLE;
      ST_ERROR: state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      len_q <= '0;
      cnt   <= '0;
    end else if (abort) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      if (accept && (burst_len != '0)) begin
        len_q <= burst_len;
      end
      if (rx_go) begin
        cnt <= len_q;
      end else if ((state == ST_STROBE) && (cnt != '0)) begin
        cnt <= cnt - ONE;
      end
    end
  end

  assign eng  = (state == ST_ENGAGE);
  assign d_s  = (state == ST_STROBE);
  assign busy = (state != ST_IDLE);
  assign done = (state == ST_DONE);
  assign err  = (state == ST_ERROR);

endmodule
